// File: rtl/bit_scan_unit.sv
// Multi-cycle bit scanner: captures a WIDTH-bit word and walks it LANES bits per clock,
// producing popcount, leading-one index, trailing-one index or parity behind START/BUSY/DONE.
module bit_scan_unit #(
  parameter int WIDTH = 15,
  parameter int LANES = 1,
  parameter int OUT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] IN,
  output logic             BUSY,
  output logic             DONE,
  output logic             ZERO,
  output logic [OUT_W-1:0] OUT
);

  localparam int S      = (WIDTH + LANES - 1) / LANES;
  localparam int PAD_W  = S * LANES;
  localparam int STEP_W = (S > 1) ? $clog2(S) : 1;

  if (OUT_W < $clog2(WIDTH + 1)) begin : g_out_w_chk
    $error("bit_scan_unit: OUT_W too narrow for WIDTH");
  end
  if (LANES < 1 || LANES > WIDTH) begin : g_lanes_chk
    $error("bit_scan_unit: LANES must be in 1..WIDTH");
  end

  typedef enum logic {IDLE, SCAN} state_t;

  state_t             state_q, state_d;
  logic [PAD_W-1:0]   op_q, op_d;
  logic [1:0]         mode_q, mode_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [OUT_W-1:0]   base_q, base_d;
  logic [OUT_W-1:0]   acc_q, acc_d;
  logic               hit_q, hit_d;
  logic               zt_q, zt_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               zero_q, zero_d;
  logic               done_q, done_d;
  logic [LANES-1:0]   slice;
  logic               last;

  function automatic logic [OUT_W-1:0] ones_in(input logic [LANES-1:0] s);
    logic [OUT_W-1:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) n = n + OUT_W'(s[i]);
    return n;
  endfunction

  function automatic logic [OUT_W-1:0] hi_index(input logic [LANES-1:0] s);
    logic [OUT_W-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) if (s[i]) r = OUT_W'(i);
    return r;
  endfunction

  function automatic logic [OUT_W-1:0] lo_index(input logic [LANES-1:0] s);
    logic [OUT_W-1:0] r;
    r = '0;
    for (int i = LANES - 1; i >= 0; i--) if (s[i]) r = OUT_W'(i);
    return r;
  endfunction

  // The operand shifts right each step, so the current slice is always the low lanes.
  assign slice = op_q[LANES-1:0];
  assign last  = (step_q == STEP_W'(S - 1));

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (START) state_d = SCAN;
      SCAN:    if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    BUSY = (state_q == SCAN);
    DONE = done_q;
    ZERO = zero_q;
    OUT  = out_q;
  end

  always_comb begin
    op_d   = op_q;
    mode_d = mode_q;
    step_d = step_q;
    base_d = base_q;
    acc_d  = acc_q;
    hit_d  = hit_q;
    zt_d   = zt_q;
    out_d  = out_q;
    zero_d = zero_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (START) begin
        op_d             = '0;
        op_d[WIDTH-1:0]  = IN;
        mode_d           = MODE;
        step_d           = '0;
        base_d           = '0;
        acc_d            = '0;
        hit_d            = 1'b0;
        zt_d             = 1'b1;
      end
    end else begin
      op_d   = op_q >> LANES;
      step_d = step_q + STEP_W'(1);
      base_d = base_q + OUT_W'(LANES);
      zt_d   = zt_q & (slice == '0);
      case (mode_q)
        2'b00: acc_d = acc_q + ones_in(slice);
        2'b01: if (slice != '0) acc_d = base_q + hi_index(slice);
        2'b10: begin
          if (slice != '0 && !hit_q) begin
            acc_d = base_q + lo_index(slice);
            hit_d = 1'b1;
          end
        end
        default: acc_d[0] = acc_q[0] ^ (^slice);
      endcase
      if (last) begin
        out_d  = acc_d;
        zero_d = zt_d;
        done_d = 1'b1;
      end
    end
  end

  // Operand and mode are pure data: they are always reloaded before use.
  always_ff @(posedge CLK) begin
    op_q   <= op_d;
    mode_q <= mode_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      step_q <= '0;
      base_q <= '0;
      acc_q  <= '0;
      hit_q  <= 1'b0;
      zt_q   <= 1'b0;
      out_q  <= '0;
      zero_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      step_q <= step_d;
      base_q <= base_d;
      acc_q  <= acc_d;
      hit_q  <= hit_d;
      zt_q   <= zt_d;
      out_q  <= out_d;
      zero_q <= zero_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_bit_scan_unit.sv
// Bench for bit_scan_unit: a LANES=1 and a LANES=4 instance checked against a plain reference model.
module tb_bit_scan_unit;

  logic        clk;
  logic        rst;
  logic        start_s [2];
  logic [14:0] in_s    [2];
  logic [1:0]  mode_s  [2];
  logic        busy_s  [2];
  logic        done_s  [2];
  logic        zero_s  [2];
  logic [7:0]  out_s   [2];

  int errors = 0;
  int checks = 0;
  int ops [2];
  int dcnt0 = 0;
  int dcnt1 = 0;

  bit_scan_unit #(.WIDTH(15), .LANES(1), .OUT_W(8)) u_l1 (
    .CLK(clk), .RST(rst), .START(start_s[0]), .MODE(mode_s[0]), .IN(in_s[0]),
    .BUSY(busy_s[0]), .DONE(done_s[0]), .ZERO(zero_s[0]), .OUT(out_s[0])
  );

  bit_scan_unit #(.WIDTH(15), .LANES(4), .OUT_W(8)) u_l4 (
    .CLK(clk), .RST(rst), .START(start_s[1]), .MODE(mode_s[1]), .IN(in_s[1]),
    .BUSY(busy_s[1]), .DONE(done_s[1]), .ZERO(zero_s[1]), .OUT(out_s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done_s[0]) dcnt0++;
    if (done_s[1]) dcnt1++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {zero, result} computed directly from the word.
  function automatic logic [8:0] ref_model(input logic [1:0] m, input logic [14:0] v);
    int hi, lo;
    logic [7:0] r;
    hi = -1;
    lo = -1;
    for (int i = 0; i < 15; i++) begin
      if (v[i]) begin
        if (lo < 0) lo = i;
        hi = i;
      end
    end
    case (m)
      2'd0:    r = 8'($countones(v));
      2'd1:    r = (hi < 0) ? 8'd0 : 8'(hi);
      2'd2:    r = (lo < 0) ? 8'd0 : 8'(lo);
      default: r = {7'd0, ^v};
    endcase
    return {(v == 15'd0), r};
  endfunction

  task automatic do_op(input int d, input logic [14:0] v, input logic [1:0] m,
                       input bit chain, input bit noise, input string tag);
    logic [8:0] e;
    int cyc, bcnt, lat;
    e   = ref_model(m, v);
    lat = (d == 0) ? 15 : 4;
    start_s[d] = 1'b1;
    in_s[d]    = v;
    mode_s[d]  = m;
    tick();
    start_s[d] = 1'b0;
    ops[d]++;
    cyc  = 0;
    bcnt = 0;
    while (!done_s[d] && cyc < 40) begin
      if (busy_s[d]) bcnt++;
      if (noise) begin
        start_s[d] = 1'b1;
        in_s[d]    = 15'($urandom);
        mode_s[d]  = 2'($urandom);
      end
      tick();
      cyc++;
    end
    start_s[d] = 1'b0;
    chk({tag, " latency"}, cyc, lat);
    chk({tag, " busy cycles"}, bcnt, lat);
    chk({tag, " busy at done"}, busy_s[d], 0);
    chk({tag, " out"}, out_s[d], e[7:0]);
    chk({tag, " zero"}, zero_s[d], e[8]);
    if (!chain) begin
      tick();
      chk({tag, " done pulse"}, done_s[d], 0);
      chk({tag, " out held"}, out_s[d], e[7:0]);
    end
  endtask

  initial begin
    int snap;
    logic [14:0] v;
    ops[0] = 0;
    ops[1] = 0;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0;
      in_s[d]    = '0;
      mode_s[d]  = '0;
    end
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      chk("reset busy", busy_s[d], 0);
      chk("reset done", done_s[d], 0);
      chk("reset out",  out_s[d], 0);
      chk("reset zero", zero_s[d], 0);
    end
    rst = 1'b0;
    tick();

    do_op(0, 15'd0, 2'd0, 0, 0, "zero popcount");
    do_op(0, 15'b010101010100101, 2'd0, 0, 0, "pattern pop");
    do_op(0, 15'b010101010100101, 2'd1, 0, 0, "pattern lead");
    do_op(0, 15'b010101010100101, 2'd2, 0, 0, "pattern trail");
    do_op(0, 15'b010101010100101, 2'd3, 0, 0, "pattern parity");
    do_op(0, 15'h7FFF, 2'd0, 1, 0, "ones pop chained");
    do_op(0, 15'h7FFF, 2'd3, 0, 0, "ones parity back-to-back");
    do_op(1, 15'h4000, 2'd1, 0, 0, "l4 lead msb");
    do_op(1, 15'h4000, 2'd2, 0, 0, "l4 trail msb");
    do_op(1, 15'd0, 2'd1, 0, 0, "l4 zero lead");
    do_op(0, 15'h5A3C, 2'd2, 0, 1, "noise l1");
    do_op(1, 15'h1234, 2'd0, 0, 1, "noise l4");

    do_op(0, 15'h7FFF, 2'd0, 0, 0, "pre-reset");
    start_s[0] = 1'b1;
    in_s[0]    = 15'h2B6D;
    mode_s[0]  = 2'd0;
    tick();
    start_s[0] = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort busy", busy_s[0], 0);
    chk("abort done", done_s[0], 0);
    chk("abort out",  out_s[0], 0);
    chk("abort zero", zero_s[0], 0);
    snap = dcnt0;
    repeat (20) tick();
    chk("abort no done", dcnt0, snap);
    do_op(0, 15'h2B6D, 2'd1, 0, 0, "after abort");

    for (int i = 0; i < 24; i++) begin
      v = ($urandom_range(0, 7) == 0) ? 15'd0 : 15'($urandom);
      do_op(i % 2, v, 2'($urandom), 0, 0, "random");
    end

    chk("done count l1", dcnt0, ops[0]);
    chk("done count l4", dcnt1, ops[1]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
